// File: rtl/fifo_word_packer.sv
// Packs PACK show-ahead FIFO entries into one wide valid/ready word.
// Partial words close on flush or after TIMEOUT idle cycles.
module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fifo_val,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  output logic                       fifo_read,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]            out_keep
);

  localparam int IW = $clog2(PACK) + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int WW = DATA_WIDTH * PACK;

  localparam logic [IW-1:0] LAST = IW'(PACK - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t          state_q, state_n;
  logic [IW-1:0]   idx_q, idx_n;
  logic [TW-1:0]   tmr_q, tmr_n;
  logic [WW-1:0]   data_q, data_n;
  logic [PACK-1:0] keep_q, keep_n;
  logic            pop;

  assign pop       = reset & (state_q == COLLECT) & fifo_val;
  assign fifo_read = pop;
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_keep  = keep_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      tmr_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      tmr_q   <= tmr_n;
      data_q  <= data_n;
      keep_q  <= keep_n;
    end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    tmr_n   = tmr_q;
    data_n  = data_q;
    keep_n  = keep_q;
    unique case (state_q)
      COLLECT: begin
        if (pop) begin
          for (int k = 0; k < PACK; k++) begin
            if (idx_q == IW'(k)) begin
              data_n[k*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
              keep_n[k] = 1'b1;
            end
          end
          idx_n = idx_q + IW'(1);
          tmr_n = '0;
          // A flush alongside a pop closes the word with that entry.
          if (idx_q == LAST || flush) begin
            state_n = HOLD;
          end
        end else if (idx_q != '0) begin
          if (flush) begin
            state_n = HOLD;
            tmr_n   = '0;
          end else if (TIMEOUT > 0) begin
            if (tmr_q != TMAX) begin
              tmr_n = tmr_q + TW'(1);
            end
            if (tmr_n == TMAX) begin
              state_n = HOLD;
              tmr_n   = '0;
            end
          end
        end else begin
          tmr_n = '0;
        end
      end
      HOLD: begin
        tmr_n = '0;
        if (out_ready) begin
          state_n = COLLECT;
          idx_n   = '0;
          data_n  = '0;
          keep_n  = '0;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed vector bench for fifo_word_packer (8-bit lanes, PACK=4).
// Table-driven cycles plus timeout, backpressure and async-reset sequences.
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_val;
  logic [7:0]  fifo_data;
  logic        fifo_read;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_word_packer #(
    .DATA_WIDTH(8),
    .PACK(4),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fifo_val(fifo_val),
    .fifo_data(fifo_data),
    .fifo_read(fifo_read),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_keep(out_keep)
  );

  typedef struct {
    logic        rst;
    logic        val;
    logic [7:0]  d;
    logic        fl;
    logic        rdy;
    logic        e_read;
    logic        e_valid;
    logic [31:0] e_data;
    logic [3:0]  e_keep;
  } vec_t;

  vec_t tv[17];

  function automatic vec_t mk(
    input logic rst, input logic val,
    input logic [7:0] d, input logic fl,
    input logic rdy, input logic e_read,
    input logic e_valid, input logic [31:0] e_data,
    input logic [3:0] e_keep);
    vec_t v;
    v.rst = rst; v.val = val; v.d = d;
    v.fl = fl; v.rdy = rdy;
    v.e_read = e_read; v.e_valid = e_valid;
    v.e_data = e_data; v.e_keep = e_keep;
    return v;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
    end
  endtask

  task automatic check_all(input string tag,
                           input logic e_read,
                           input logic e_valid,
                           input logic [31:0] e_data,
                           input logic [3:0] e_keep);
    check({tag, " read"}, 32'(fifo_read), 32'(e_read));
    check({tag, " valid"}, 32'(out_valid), 32'(e_valid));
    check({tag, " data"}, out_data, e_data);
    check({tag, " keep"}, 32'(out_keep), 32'(e_keep));
  endtask

  task automatic drive(input logic val, input logic [7:0] d,
                       input logic fl, input logic rdy);
    fifo_val  = val;
    fifo_data = d;
    flush     = fl;
    out_ready = rdy;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2 reset = 1'b0;

    // rst val  d    fl rdy   rd vld data           keep
    tv[0]  = mk(0, 1, 8'h11, 0, 0,  0, 0, 32'h00000000, 4'b0000);
    tv[1]  = mk(1, 1, 8'h11, 0, 0,  1, 0, 32'h00000000, 4'b0000);
    tv[2]  = mk(1, 1, 8'h22, 0, 0,  1, 0, 32'h00000011, 4'b0001);
    tv[3]  = mk(1, 1, 8'h33, 0, 0,  1, 0, 32'h00002211, 4'b0011);
    tv[4]  = mk(1, 1, 8'h44, 0, 1,  1, 0, 32'h00332211, 4'b0111);
    tv[5]  = mk(1, 0, 8'h00, 0, 1,  0, 1, 32'h44332211, 4'b1111);
    tv[6]  = mk(1, 0, 8'h00, 0, 0,  0, 0, 32'h00000000, 4'b0000);
    tv[7]  = mk(1, 1, 8'h5C, 0, 0,  1, 0, 32'h00000000, 4'b0000);
    tv[8]  = mk(1, 0, 8'h00, 1, 0,  0, 0, 32'h0000005C, 4'b0001);
    tv[9]  = mk(1, 0, 8'h00, 1, 0,  0, 1, 32'h0000005C, 4'b0001);
    tv[10] = mk(1, 0, 8'h00, 0, 1,  0, 1, 32'h0000005C, 4'b0001);
    tv[11] = mk(1, 0, 8'h00, 1, 0,  0, 0, 32'h00000000, 4'b0000);
    tv[12] = mk(1, 0, 8'h00, 0, 0,  0, 0, 32'h00000000, 4'b0000);
    tv[13] = mk(1, 1, 8'hB1, 0, 0,  1, 0, 32'h00000000, 4'b0000);
    tv[14] = mk(1, 1, 8'hB2, 1, 0,  1, 0, 32'h000000B1, 4'b0001);
    tv[15] = mk(1, 1, 8'hC3, 0, 0,  0, 1, 32'h0000B2B1, 4'b0011);
    tv[16] = mk(1, 1, 8'hC3, 0, 1,  0, 1, 32'h0000B2B1, 4'b0011);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      reset = tv[i].rst;
      drive(tv[i].val, tv[i].d, tv[i].fl, tv[i].rdy);
      #1;
      check_all($sformatf("vec%0d", i), tv[i].e_read,
                tv[i].e_valid, tv[i].e_data, tv[i].e_keep);
    end

    // Idle timeout closes a two-lane word after 15 idle cycles.
    @(negedge clk);
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    #1 check_all("to pop1", 1, 0, 32'h0, 4'b0000);
    @(negedge clk);
    drive(1'b1, 8'hA2, 1'b0, 1'b0);
    #1 check_all("to pop2", 1, 0, 32'h000000A1, 4'b0001);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      #1 check($sformatf("to idle%0d valid", i),
               32'(out_valid), 32'd0);
    end
    @(negedge clk);
    #1 check_all("to word", 0, 1, 32'h0000A2A1, 4'b0011);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1 check_all("to after", 0, 0, 32'h0, 4'b0000);

    // Backpressure on a full word with the FIFO still non-empty.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 8'(i + 1), 1'b0, 1'b0);
      #1 check($sformatf("bp pop%0d read", i),
               32'(fifo_read), 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 8'h05, 1'b0, 1'b0);
      #1 check_all($sformatf("bp stall%0d", i),
                   0, 1, 32'h04030201, 4'b1111);
    end
    @(negedge clk);
    drive(1'b1, 8'h05, 1'b0, 1'b1);
    #1 check_all("bp accept", 0, 1, 32'h04030201, 4'b1111);
    @(negedge clk);
    drive(1'b1, 8'h05, 1'b0, 1'b0);
    #1 check_all("bp resume", 1, 0, 32'h0, 4'b0000);
    @(negedge clk);
    drive(1'b1, 8'h06, 1'b0, 1'b0);
    #1 check_all("rs pop2", 1, 0, 32'h00000005, 4'b0001);

    // Async reset with two lanes collected.
    @(negedge clk);
    drive(1'b1, 8'h07, 1'b0, 1'b0);
    #1 check_all("rs idx2", 1, 0, 32'h00000605, 4'b0011);
    #1 reset = 1'b0;
    #1 check_all("rs async", 0, 0, 32'h0, 4'b0000);
    @(negedge clk);
    #1 check_all("rs held", 0, 0, 32'h0, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    #1 check_all("rs rel", 1, 0, 32'h0, 4'b0000);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1 check_all("rs lane0", 0, 0, 32'h00000077, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
